// File: rtl/bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_controller
//  Description : Single-bomb lifecycle engine. Latches a drop request at the
//                player's tile, runs a fuse timer, then a blast timer, and
//                drives the bomb / explosion sprite enables and colours plus a
//                player-hit flag for game-over logic.
//                Optional macro BOMB_BLINK_EN: blink the bomb during the final
//                quarter of the fuse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_controller #(
    parameter int          FUSE_CYCLES   = 300000000,
    parameter int          BLAST_CYCLES  = 50000000,
    parameter int          TILE_SHIFT    = 5,
    parameter int          BLAST_RANGE   = 2,
    parameter logic [11:0] BOMB_RGB      = 12'h222,
    parameter logic [11:0] EXPLOSION_RGB = 12'hF80
) (
    input  logic        sys_clk,
    input  logic        Reset,
    input  logic        drop,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [9:0]  v_x,
    input  logic [9:0]  v_y,
    output logic        bomb_on,
    output logic        explosion_on,
    output logic [11:0] bomb_rgb,
    output logic [11:0] explosion_rgb,
    output logic        bomb_active,
    output logic        exploding,
    output logic        detonate,
    output logic        player_hit
);

    localparam int MAX_CYCLES = (FUSE_CYCLES > BLAST_CYCLES) ? FUSE_CYCLES : BLAST_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] FUSE_LAST  = CNT_W'(FUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLAST_LAST = CNT_W'(BLAST_CYCLES - 1);
    localparam logic [10:0]      HALF_TILE  = 11'(1 << (TILE_SHIFT - 1));
    localparam logic [10:0]      RANGE      = 11'(BLAST_RANGE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FUSE  = 2'd1,
        ST_BLAST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [10:0]        bomb_tx_q, bomb_tx_d;
    logic [10:0]        bomb_ty_q, bomb_ty_d;
    logic               drop_q, drop_d;

    logic [10:0]        px, py;
    logic [10:0]        vx_t, vy_t;
    logic               drop_rise;
    logic               blink_gate;

    // Unsigned larger-minus-smaller so arms never wrap across the screen edge
    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic in_cross(input logic [10:0] x,  input logic [10:0] y,
                                      input logic [10:0] tx, input logic [10:0] ty);
        return ((y == ty) && (abs_diff(x, tx) <= RANGE)) ||
               ((x == tx) && (abs_diff(y, ty) <= RANGE));
    endfunction

    // Player tile is the one under the sprite centre; 11-bit sum cannot overflow
    assign px        = ({1'b0, b_x} + HALF_TILE) >> TILE_SHIFT;
    assign py        = ({1'b0, b_y} + HALF_TILE) >> TILE_SHIFT;
    assign vx_t      = {1'b0, v_x} >> TILE_SHIFT;
    assign vy_t      = {1'b0, v_y} >> TILE_SHIFT;
    assign drop_rise = drop & ~drop_q;

    // Next-state logic: drops are only honoured in IDLE, never queued
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bomb_tx_d = bomb_tx_q;
        bomb_ty_d = bomb_ty_q;
        drop_d    = drop;
        case (state_q)
            ST_IDLE: begin
                if (drop_rise) begin
                    bomb_tx_d = px;
                    bomb_ty_d = py;
                    cnt_d     = '0;
                    state_d   = ST_FUSE;
                end
            end
            ST_FUSE: begin
                if (cnt_q == FUSE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_BLAST;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BLAST: begin
                if (cnt_q == BLAST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, timer and latched bomb tile; reset aborts any bomb in flight
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bomb_tx_q <= '0;
            bomb_ty_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bomb_tx_q <= bomb_tx_d;
            bomb_ty_q <= bomb_ty_d;
            drop_q    <= drop_d;
        end
    end

`ifdef BOMB_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_START = CNT_W'(FUSE_CYCLES - FUSE_CYCLES / 4);

    logic [21:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;

    // Free-running divider; blink bit flips each time the 22-bit count wraps
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = (&blink_cnt_q) ? ~blink_q : blink_q;
    end

    // Blink divider registers
    always_ff @(posedge sys_clk or posedge Reset) begin
        if (Reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink_gate = (cnt_q < BLINK_START) | blink_q;
`else
    assign blink_gate = 1'b1;
`endif

    // Status decoded straight from state so they track reset immediately
    assign bomb_active = (state_q == ST_FUSE);
    assign exploding   = (state_q == ST_BLAST);
    assign detonate    = (state_q == ST_FUSE) && (cnt_q == FUSE_LAST);

    // Pixel enables are combinational to stay aligned with the other sprites
    assign bomb_on       = bomb_active && (vx_t == bomb_tx_q) && (vy_t == bomb_ty_q) && blink_gate;
    assign explosion_on  = exploding && in_cross(vx_t, vy_t, bomb_tx_q, bomb_ty_q);
    assign player_hit    = exploding && in_cross(px, py, bomb_tx_q, bomb_ty_q);
    assign bomb_rgb      = bomb_on      ? BOMB_RGB      : 12'h000;
    assign explosion_rgb = explosion_on ? EXPLOSION_RGB : 12'h000;

endmodule
`default_nettype wire

// File: tb/tb_bomb_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_controller
//  Description : Directed scoreboard bench for bomb_controller
//                (FUSE_CYCLES=20, BLAST_CYCLES=10, 32-pixel tiles, range 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_controller;

    logic        sys_clk;
    logic        Reset;
    logic        drop;
    logic [9:0]  b_x, b_y, v_x, v_y;
    logic        bomb_on, explosion_on, bomb_active, exploding, detonate, player_hit;
    logic [11:0] bomb_rgb, explosion_rgb;

    int checks;
    int errors;
    bit done;

    string       name_q[$];
    logic [29:0] exp_q[$];

    bomb_controller #(
        .FUSE_CYCLES   (20),
        .BLAST_CYCLES  (10),
        .TILE_SHIFT    (5),
        .BLAST_RANGE   (2),
        .BOMB_RGB      (12'h222),
        .EXPLOSION_RGB (12'hF80)
    ) dut (
        .sys_clk       (sys_clk),
        .Reset         (Reset),
        .drop          (drop),
        .b_x           (b_x),
        .b_y           (b_y),
        .v_x           (v_x),
        .v_y           (v_y),
        .bomb_on       (bomb_on),
        .explosion_on  (explosion_on),
        .bomb_rgb      (bomb_rgb),
        .explosion_rgb (explosion_rgb),
        .bomb_active   (bomb_active),
        .exploding     (exploding),
        .detonate      (detonate),
        .player_hit    (player_hit)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Monitor: compare every queued expectation against the outputs at negedge
    always @(negedge sys_clk) begin
        while (exp_q.size() > 0) begin
            automatic string       nm  = name_q.pop_front();
            automatic logic [29:0] ev  = exp_q.pop_front();
            automatic logic [29:0] act = {bomb_on, explosion_on, player_hit, bomb_active,
                                          exploding, detonate, bomb_rgb, explosion_rgb};
            checks++;
            if (act !== ev) begin
                errors++;
                $display("FAIL %s got={on,exp,hit,act,expl,det,brgb,ergb}=%b_%b_%b_%b_%b_%b_%h_%h expected=%b_%b_%b_%b_%b_%b_%h_%h",
                         nm, act[29], act[28], act[27], act[26], act[25], act[24], act[23:12], act[11:0],
                         ev[29], ev[28], ev[27], ev[26], ev[25], ev[24], ev[23:12], ev[11:0]);
            end
        end
    end

    // Watchdog: the stimulus must finish within a bounded time
    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within the expected wait");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input string nm, input bit bo, input bit eo, input bit ph,
                        input bit ba, input bit ex, input bit dt);
        name_q.push_back(nm);
        exp_q.push_back({bo, eo, ph, ba, ex, dt,
                         bo ? 12'h222 : 12'h000,
                         eo ? 12'hF80 : 12'h000});
    endtask

    // Expectation k cycles after a bomb drop, with pixel and player on the bomb tile
    task automatic push_phase(input string nm, input int k);
        if (k < 20)      push(nm, 1, 0, 0, 1, 0, k == 19);
        else if (k < 30) push(nm, 0, 1, 1, 0, 1, 0);
        else             push(nm, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_v(input int x, input int y);
        v_x = 10'(x);
        v_y = 10'(y);
    endtask

    task automatic set_b(input int x, input int y);
        b_x = 10'(x);
        b_y = 10'(y);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done   = 1'b0;
        Reset  = 1'b1;
        drop   = 1'b0;
        set_b(0, 0);
        set_v(0, 0);

        step();
        checks++;
        if ({bomb_on, explosion_on, player_hit, bomb_active, exploding, detonate,
             bomb_rgb, explosion_rgb} !== 30'd0) begin
            errors++;
            $display("FAIL reset_state_direct: outputs not all zero during reset");
        end
        push("reset_state", 0, 0, 0, 0, 0, 0);
        step();
        Reset = 1'b0;
        push("idle_after_reset", 0, 0, 0, 0, 0, 0);

        // ---- Drop at tile (3,2), fuse, then blast geometry ----
        set_b(100, 60);
        set_v(100, 70);
        drop = 1'b1;
        push("t1_pre_drop", 0, 0, 0, 0, 0, 0);
        step();
        drop = 1'b0;
        push("t1_bomb_on_tile", 1, 0, 0, 1, 0, 0);
        step();
        set_v(140, 70);
        push("t1_bomb_off_tile", 0, 0, 0, 1, 0, 0);
        for (int k = 2; k < 20; k++) begin
            step();
            set_v(100, 70);
            push_phase($sformatf("t1_fuse_k%0d", k), k);
        end
        begin
            int vx [10] = '{32, 160, 96, 96, 192, 128, 0, 96, 64, 96};
            int vy [10] = '{64, 64, 0, 128, 64, 96, 64, 160, 64, 64};
            bit eo [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
            for (int i = 0; i < 10; i++) begin
                step();
                set_v(vx[i], vy[i]);
                push($sformatf("t2_blast_tile_%0d_%0d", vx[i] / 32, vy[i] / 32), 0, eo[i], 1, 0, 1, 0);
            end
        end
        step();
        set_v(100, 70);
        push("t2_back_to_idle", 0, 0, 0, 0, 0, 0);
        step();
        push("t2_idle_stays", 0, 0, 0, 0, 0, 0);

        // ---- Bomb at tile (0,0): clipping and player hit ----
        set_b(0, 0);
        set_v(0, 0);
        drop = 1'b1;
        push("t3_pre_drop", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            drop = 1'b0;
            push_phase($sformatf("t3_fuse_k%0d", k), k);
        end
        begin
            int vx [10] = '{992, 0, 64, 0, 96, 0, 0, 0, 0, 0};
            int vy [10] = '{0, 448, 0, 64, 0, 0, 0, 0, 0, 0};
            int bx [10] = '{0, 0, 0, 0, 0, 0, 32, 1023, 47, 80};
            int by [10] = '{0, 0, 0, 0, 0, 64, 32, 0, 0, 0};
            bit eo [10] = '{0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
            bit ph [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
            for (int i = 0; i < 10; i++) begin
                step();
                set_v(vx[i], vy[i]);
                set_b(bx[i], by[i]);
                push($sformatf("t3_blast_i%0d", i), 0, eo[i], ph[i], 0, 1, 0);
            end
        end
        step();
        push("t3_back_to_idle", 0, 0, 0, 0, 0, 0);

        // ---- Held drop gives exactly one bomb ----
        set_b(100, 60);
        set_v(100, 70);
        drop = 1'b1;
        push("t4_pre_hold", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 50; k++) begin
            step();
            push_phase($sformatf("t4_hold_k%0d", k), k);
        end
        drop = 1'b0;
        step();
        push("t4_released", 0, 0, 0, 0, 0, 0);

        // ---- Edges in FUSE and in the final BLAST cycle are discarded ----
        drop = 1'b1;
        push("t4b_pre_drop", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 42; k++) begin
            step();
            drop = ((k <= 2) || (k >= 5 && k <= 7) || k == 29 || k >= 31) ? 1'b1 : 1'b0;
            if (k < 30)       push_phase($sformatf("t4b_k%0d", k), k);
            else if (k < 32)  push($sformatf("t4b_idle_k%0d", k), 0, 0, 0, 0, 0, 0);
            else              push_phase($sformatf("t4b_new_k%0d", k), k - 32);
        end

        // ---- Reset in the middle of the fuse aborts at once ----
        step();
        Reset = 1'b1;
        push("t5_reset_abort", 0, 0, 0, 0, 0, 0);
        step();
        push("t5_reset_held", 0, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        drop  = 1'b0;
        step();
        push("t5_idle_after_reset", 0, 0, 0, 0, 0, 0);
        drop = 1'b1;
        for (int k = 0; k < 33; k++) begin
            step();
            drop = (k == 30) ? 1'b1 : 1'b0;
            if (k <= 30) push_phase($sformatf("t5_k%0d", k), k);
            else         push_phase($sformatf("t5_first_idle_drop_k%0d", k), k - 31);
        end

        step();
        @(negedge sys_clk);
        #1;
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
